interp_fir_seq: RTL and testbench

- Sequencer for the 8x polyphase interpolation FIR that converts 352.8 kHz to 2.8224 MHz, using the 115-tap coefficient ROM (7-bit address, signed 32-bit coefficient).
- For each accepted input sample it performs three jobs:
  - writes the sample into a 16-entry history ring;
  - walks the 8 output phases;
  - for each phase, drives coefficient-ROM and history-read addresses plus MAC control strobes.
- Sits between the input sample strobe and the MAC/output stage. It contains no arithmetic.

---
 rtl/interp_fir_seq_pkg.sv | 19 +
 rtl/interp_fir_hist_ptr.sv | 44 ++++
 rtl/interp_fir_seq.sv | 146 ++++++++++++++
 tb/tb_interp_fir_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/interp_fir_seq_pkg.sv
// Shared constants, state encoding and phase-length helper for the 8x
// polyphase interpolation FIR sequencer.
package interp_fir_seq_pkg;

  localparam int NTAP_2 = 115;
  localparam int L_2    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Number of MAC terms in phase p: ceil((ntap - p) / l).
  function automatic int terms_per_phase(input int p, input int ntap, input int l);
    return (ntap - p + l - 1) / l;
  endfunction

endpackage

// File: rtl/interp_fir_hist_ptr.sv
// History ring pointers: owns the write pointer and the newest-sample index,
// and produces the modulo read address newest - back.
module interp_fir_hist_ptr
  import interp_fir_seq_pkg::*;
#(
  parameter int HIST_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_adv,
  input  logic [HIST_AW-1:0] rd_back,
  output logic [HIST_AW-1:0] wr_ptr,
  output logic [HIST_AW-1:0] newest,
  output logic [HIST_AW-1:0] rd_addr
);

  logic [HIST_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [HIST_AW-1:0] newest_q, newest_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    newest_d = newest_q;
    if (wr_adv) begin
      wr_ptr_d = wr_ptr_q + HIST_AW'(1);
      newest_d = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      newest_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      newest_q <= newest_d;
    end
  end

  // Natural wrap of the HIST_AW-bit subtraction gives the ring modulo.
  assign rd_addr = newest_q - rd_back;
  assign wr_ptr  = wr_ptr_q;
  assign newest  = newest_q;

endmodule

// File: rtl/interp_fir_seq.sv
// Polyphase interpolation FIR sequencer: per input sample, writes history,
// then walks L phases issuing one registered MAC term per cycle.
module interp_fir_seq
  import interp_fir_seq_pkg::*;
#(
  parameter int NTAP    = NTAP_2,
  parameter int L       = L_2,
  parameter int TAP_AW  = 7,
  parameter int HIST_AW = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               samp_stb,
  input  logic               out_ready,
  output logic               hist_we,
  output logic [HIST_AW-1:0] hist_wa,
  output logic [HIST_AW-1:0] hist_ra,
  output logic [TAP_AW-1:0]  tap_addr,
  output logic               mac_en,
  output logic               mac_first,
  output logic               mac_last,
  output logic [2:0]         phase,
  output logic               busy,
  output logic               overrun
);

  state_e             state_q, state_d;
  logic [2:0]         p_q, p_d;
  logic [HIST_AW-1:0] j_q, j_d;

  logic [HIST_AW-1:0] hist_ra_q, hist_ra_d;
  logic [TAP_AW-1:0]  tap_addr_q, tap_addr_d;
  logic               mac_en_q, mac_en_d;
  logic               mac_first_q, mac_first_d;
  logic               mac_last_q, mac_last_d;
  logic [2:0]         phase_q, phase_d;
  logic               busy_q, busy_d;
  logic               overrun_q, overrun_d;

  logic               wr_adv;
  logic               is_last;
  logic [HIST_AW-1:0] wr_ptr, newest, rd_addr;

  interp_fir_hist_ptr #(.HIST_AW(HIST_AW)) u_hist_ptr (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_adv  (wr_adv),
    .rd_back (j_q),
    .wr_ptr  (wr_ptr),
    .newest  (newest),
    .rd_addr (rd_addr)
  );

  // Only IDLE accepts a sample; anywhere else it is dropped and flagged.
  assign wr_adv  = samp_stb && (state_q == IDLE);
  assign hist_we = wr_adv;
  assign hist_wa = wr_ptr;

  assign is_last = (int'(j_q) == terms_per_phase(int'(p_q), NTAP, L) - 1);

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    j_d         = j_q;
    busy_d      = (state_q != IDLE);
    overrun_d   = overrun_q | (samp_stb && (state_q != IDLE));
    hist_ra_d   = '0;
    tap_addr_d  = '0;
    mac_en_d    = 1'b0;
    mac_first_d = 1'b0;
    mac_last_d  = 1'b0;
    phase_d     = '0;
    case (state_q)
      IDLE: begin
        if (samp_stb) begin
          p_d     = '0;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (out_ready) begin
          j_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        tap_addr_d  = TAP_AW'(p_q) + TAP_AW'(L) * TAP_AW'(j_q);
        hist_ra_d   = rd_addr;
        mac_en_d    = 1'b1;
        mac_first_d = (j_q == '0);
        mac_last_d  = is_last;
        phase_d     = p_q;
        j_d         = j_q + HIST_AW'(1);
        if (is_last) begin
          if (p_q == 3'(L - 1)) begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            p_d     = p_q + 3'd1;
            state_d = WAIT;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      p_q         <= '0;
      j_q         <= '0;
      hist_ra_q   <= '0;
      tap_addr_q  <= '0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      mac_last_q  <= 1'b0;
      phase_q     <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      j_q         <= j_d;
      hist_ra_q   <= hist_ra_d;
      tap_addr_q  <= tap_addr_d;
      mac_en_q    <= mac_en_d;
      mac_first_q <= mac_first_d;
      mac_last_q  <= mac_last_d;
      phase_q     <= phase_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign hist_ra   = hist_ra_q;
  assign tap_addr  = tap_addr_q;
  assign mac_en    = mac_en_q;
  assign mac_first = mac_first_q;
  assign mac_last  = mac_last_q;
  assign phase     = phase_q;
  assign busy      = busy_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_interp_fir_seq.sv
// Scoreboard bench for interp_fir_seq: stimulus queues expected writes and
// MAC terms, a negedge monitor pops and compares whatever the DUT issues.
module tb_interp_fir_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       samp_stb = 1'b0;
  logic       out_ready = 1'b1;
  logic       hist_we;
  logic [3:0] hist_wa, hist_ra;
  logic [6:0] tap_addr;
  logic       mac_en, mac_first, mac_last;
  logic [2:0] phase;
  logic       busy, overrun;

  typedef struct packed {
    logic [6:0] tap;
    logic [3:0] ra;
    logic       first;
    logic       last;
    logic [2:0] ph;
  } term_t;

  term_t      exp_q[$];
  logic [3:0] we_q[$];
  term_t      mon_e;
  int         checks = 0;
  int         failures = 0;
  int         nlast = 0;

  interp_fir_seq dut (
    .clk(clk), .rst_n(rst_n), .samp_stb(samp_stb), .out_ready(out_ready),
    .hist_we(hist_we), .hist_wa(hist_wa), .hist_ra(hist_ra), .tap_addr(tap_addr),
    .mac_en(mac_en), .mac_first(mac_first), .mac_last(mac_last), .phase(phase),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected MAC terms for one sample: tap = p + 8j, ring read = newest - j.
  task automatic push_sample(input logic [3:0] wa);
    we_q.push_back(wa);
    for (int p = 0; p < 8; p++) begin
      for (int j = 0; p + 8 * j < 115; j++) begin
        term_t t;
        t.tap   = 7'(p + 8 * j);
        t.ra    = wa - 4'(j);
        t.first = (j == 0);
        t.last  = (p + 8 * (j + 1) >= 115);
        t.ph    = 3'(p);
        exp_q.push_back(t);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (hist_we) begin
        if (we_q.size() == 0) chk("unexpected_hist_we", 32'(hist_we), 32'd0);
        else chk("hist_wa", 32'(hist_wa), 32'(we_q.pop_front()));
      end
      if (mac_en) begin
        if (mac_last) nlast++;
        if (exp_q.size() == 0) chk("unexpected_mac_en", 32'(mac_en), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          chk("term{tap,ra,first,last,ph}", 32'({tap_addr, hist_ra, mac_first, mac_last, phase}),
              32'(mon_e));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [3:0] wa);
    push_sample(wa);
    samp_stb = 1'b1;
    tick();
    samp_stb = 1'b0;
  endtask

  // Counts cycles busy stays high, starting from the sample edge.
  task automatic wait_idle(output int cyc);
    cyc = 1;
    for (int k = 0; k < 400; k++) begin
      tick();
      if (!busy) return;
      cyc++;
    end
    chk("busy_timeout", 32'(busy), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({hist_we, hist_wa, hist_ra, tap_addr, mac_en, mac_first, mac_last,
                   phase, busy, overrun}), 32'd0);
  endtask

  initial begin
    int  cyc;
    int  n;
    bit  found;
    bit  stall_en;

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_outputs");
    rst_n = 1'b1;
    tick();
    chk_all_zero("idle_outputs");

    // Single sample, ready held high.
    nlast = 0;
    send(4'd0);
    chk("busy_rise", 32'(busy), 32'd1);
    wait_idle(cyc);
    chk("seq_cycles", 32'(cyc), 32'd123);
    @(negedge clk);
    #1;
    chk("mac_last_count", 32'(nlast), 32'd8);
    chk("t1_terms_left", 32'(exp_q.size()), 32'd0);
    tick();

    // Second sample: reads walk 1, 0, 15, ... through the ring wrap.
    send(4'd1);
    tick();
    chk("first_term_latency", 32'(mac_en), 32'd0);
    tick();
    chk("t2_term0", 32'({tap_addr, hist_ra, mac_first}), 32'({7'd0, 4'd1, 1'b1}));
    tick();
    chk("t2_term1", 32'({tap_addr, hist_ra, mac_first}), 32'({7'd8, 4'd0, 1'b0}));
    tick();
    chk("t2_term2_wrap", 32'({tap_addr, hist_ra}), 32'({7'd16, 4'd15}));
    wait_idle(cyc);
    tick();

    // Stall in WAIT ahead of phase 3.
    send(4'd2);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (mac_en && mac_last && phase == 3'd2) found = 1'b1;
    end
    chk("phase2_end_seen", 32'(found), 32'd1);
    out_ready = 1'b0;
    stall_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      stall_en |= mac_en;
    end
    chk("stall_mac_en", 32'(stall_en), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
    out_ready = 1'b1;
    tick();
    chk("resume_gap", 32'(mac_en), 32'd0);
    tick();
    chk("resume_tap", 32'({mac_en, mac_first, tap_addr}), 32'({1'b1, 1'b1, 7'd3}));
    wait_idle(cyc);
    tick();

    // Overrun at RUN cycle 50.
    chk("overrun_clear", 32'(overrun), 32'd0);
    send(4'd3);
    n = 0;
    for (int k = 0; k < 300 && n < 50; k++) begin
      tick();
      if (mac_en) n++;
    end
    chk("run50_reached", 32'(n), 32'd50);
    samp_stb = 1'b1;
    tick();
    samp_stb = 1'b0;
    chk("overrun_set", 32'({overrun, busy}), 32'({1'b1, 1'b1}));
    wait_idle(cyc);
    @(negedge clk);
    #1;
    chk("overrun_terms_left", 32'(exp_q.size()), 32'd0);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    tick();
    send(4'd4);
    wait_idle(cyc);
    tick();

    // Reset mid-sequence at phase 5, term 7.
    send(4'd5);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (mac_en && phase == 3'd5 && tap_addr == 7'd61) found = 1'b1;
    end
    chk("p5_t7_seen", 32'(found), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    exp_q.delete();
    we_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(4'd0);
    wait_idle(cyc);

    // Sixteen back-to-back samples; write address wraps 15 -> 0.
    for (int i = 1; i <= 16; i++) begin
      send(4'(i));
      wait_idle(cyc);
      chk("b2b_cycles", 32'(cyc), 32'd123);
    end
    chk("b2b_no_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    #1;
    chk("final_terms_left", 32'(exp_q.size()), 32'd0);
    chk("final_writes_left", 32'(we_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
